// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: op encodings, main-control
// aoi codes, R-type function codes and the sequencer FSM states.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] AOI_ADD   = 2'b00;
  localparam logic [1:0] AOI_SUB   = 2'b01;
  localparam logic [1:0] AOI_RTYPE = 2'b10;
  localparam logic [1:0] AOI_OR    = 2'b11;

  localparam logic [3:0] FC_ADD = 4'b0000;
  localparam logic [3:0] FC_SUB = 4'b0010;
  localparam logic [3:0] FC_AND = 4'b0100;
  localparam logic [3:0] FC_OR  = 4'b0101;
  localparam logic [3:0] FC_SLT = 4'b1010;
  localparam logic [3:0] FC_MUL = 4'b1000;
  localparam logic [3:0] FC_DIV = 4'b1001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational aoi/function-code decoder shared with the single-cycle core.
// Divide decode is present only when ALUCU_DIV_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FC_W = 4
) (
  input  logic [1:0]      aoi,
  input  logic [FC_W-1:0] functionCode,
  output logic [2:0]      op,
  output logic            isMulti,
  output logic            isDiv,
  output logic            illegal
);

  logic fc_hi_zero;

  // Only the low nibble is decoded; any set upper bit makes the code illegal.
  assign fc_hi_zero = ((functionCode >> 4) == '0);

  // Map aoi (and for R-type the function code) to an ALU op; unknown -> NOP+illegal.
  always_comb begin
    op      = OP_NOP;
    isMulti = 1'b0;
    isDiv   = 1'b0;
    illegal = 1'b0;
    case (aoi)
      AOI_ADD: op = OP_ADD;
      AOI_SUB: op = OP_SUB;
      AOI_OR:  op = OP_OR;
      AOI_RTYPE: begin
        if (!fc_hi_zero) begin
          illegal = 1'b1;
        end else begin
          case (functionCode[3:0])
            FC_ADD: op = OP_ADD;
            FC_SUB: op = OP_SUB;
            FC_AND: op = OP_AND;
            FC_OR:  op = OP_OR;
            FC_SLT: op = OP_SLT;
            FC_MUL: begin
              op      = OP_MUL;
              isMulti = 1'b1;
            end
            FC_DIV: begin
`ifdef ALUCU_DIV_EN
              op      = OP_DIV;
              isMulti = 1'b1;
              isDiv   = 1'b1;
`else
              illegal = 1'b1;
`endif
            end
            default: illegal = 1'b1;
          endcase
        end
      end
      // X/Z on aoi falls through here in four-state simulation.
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registers the decoded ALU op for EX and holds off new
// work for the occupancy of multiply/divide via an IDLE/MULTI FSM and a down
// counter. Optional macro ALUCU_DIV_EN compiles in divide decode and
// DIV_CYCLES occupancy.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FC_W       = 4,
  parameter int OP_W       = 3,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inValid,
  output logic            inReady,
  input  logic [1:0]      aoi,
  input  logic [FC_W-1:0] functionCode,
  output logic [OP_W-1:0] op,
  output logic            opValid,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

`ifdef ALUCU_DIV_EN
  localparam int CNT_MAX  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int DIV_LOAD = DIV_CYCLES - 1;
`else
  // Without the divider DIV_CYCLES has no effect; it is referenced only so
  // the parameter list is identical in both builds.
  localparam int CNT_MAX  = MUL_CYCLES + 0 * DIV_CYCLES;
  localparam int DIV_LOAD = MUL_CYCLES - 1;
`endif
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int MUL_LOAD = MUL_CYCLES - 1;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            op_valid_q, op_valid_d;
  logic            illegal_q, illegal_d;

  logic [2:0]      dec_op;
  logic            dec_multi;
  logic            dec_div;
  logic            dec_illegal;

  alu_ctrl_decode #(.FC_W(FC_W)) u_decode (
    .aoi          (aoi),
    .functionCode (functionCode),
    .op           (dec_op),
    .isMulti      (dec_multi),
    .isDiv        (dec_div),
    .illegal      (dec_illegal)
  );

  // Next-state: accept in IDLE, count down occupancy in MULTI.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    op_valid_d = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          op_d       = OP_W'(dec_op);
          op_valid_d = 1'b1;
          illegal_d  = dec_illegal;
          if (dec_multi) begin
            cnt_d   = dec_div ? CNT_W'(DIV_LOAD) : CNT_W'(MUL_LOAD);
            state_d = ST_MULTI;
          end
        end
      end
      ST_MULTI: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registers; reset aborts any multi-cycle op and discards that cycle's input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_W'(OP_NOP);
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign inReady = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_MULTI);
  assign done    = (state_q == ST_MULTI) && (cnt_q == '0);
  assign op      = op_q;
  assign opValid = op_valid_q;
  assign illegal = illegal_q;

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised successor to the combinational ALU control unit. It decodes the main-control ALU opcode (`aoi`) and the instruction function code into a registered ALU operation for the EX stage. It also sequences multi-cycle multiply/divide operations with a ready/busy/done handshake toward the hazard unit. It sits between the ID/EX pipeline register and the ALU/multiplier datapath.

## Interface
Parameters:
- `FC_W`, default 4: function-code width; only the low 4 bits are decoded, upper bits must be zero or the code is illegal.
- `OP_W`, default 3: ALU op width; minimum 3, upper bits zero-filled.
- `MUL_CYCLES`, default 4: multiply occupancy in cycles, ≥1.
- `DIV_CYCLES`, default 8: divide occupancy in cycles, ≥1.

Ports:
- `clk` in 1: clock; the block has one clock.
- `reset` in 1: reset, synchronous, active-high.
- `inValid` in 1: `aoi`/`functionCode` valid this cycle.
- `inReady` out 1: block can accept.
- `aoi` in 2: ALU opcode from main control.
- `functionCode` in `FC_W`: R-type function field.
- `op` out `OP_W`: registered ALU operation.
- `opValid` out 1: one-cycle pulse, `op` newly updated.
- `busy` out 1: multi-cycle op in progress.
- `done` out 1: one-cycle pulse in final busy cycle.
- `illegal` out 1: one-cycle pulse with `opValid`, undecodable input.

## Operation
- Op encodings: AND=000, OR=001, ADD=010, MUL=011, DIV=100, NOP=101, SUB=110, SLT=111.
- `aoi` decode:
  - 00 → ADD
  - 01 → SUB
  - 11 → OR
  - 10 → decode `functionCode`:
    - 0000 → ADD
    - 0010 → SUB
    - 0100 → AND
    - 0101 → OR
    - 1010 → SLT
    - 1000 → MUL
    - 1001 → DIV
    - any other code → NOP with `illegal`.
  - Any X/Z on `aoi` while `inValid` → NOP with `illegal`.
- FSM states IDLE and MULTI.
  - `inReady` = (state == IDLE).
- IDLE, `inValid`=1:
  - Register decoded `op`.
  - Pulse `opValid` next cycle.
  - For MUL/DIV: load counter with N−1 (N = `MUL_CYCLES` or `DIV_CYCLES`) and go to MULTI.
- IDLE, `inValid`=0: all registers hold; `op` keeps its last value.
- MULTI:
  - `busy`=1; `inValid` is ignored (no accept).
  - Counter decrements each cycle.
  - When the counter is 0: `done`=1, next state IDLE.
- Counter width is `$clog2(max(MUL_CYCLES,DIV_CYCLES))`, minimum 1; it never wraps below 0.
- Reset values:
  - `op`=NOP
  - `opValid`=0, `busy`=0, `done`=0, `illegal`=0
  - state=IDLE, so `inReady`=1 from the first cycle after reset.
- Reset mid-MULTI aborts immediately: no `done` pulse, counter cleared.
- Input in the reset cycle is discarded.

## Timing
- Decode latency: accept at cycle T → `op`/`opValid`/`illegal` at T+1.
- Multi-cycle op with N cycles, accepted at T:
  - `busy` high T+1..T+N.
  - `done` at T+N.
  - `inReady` low T+1..T+N, high T+N+1.
- N=1 case: `busy` and `done` both high only at T+1.
- Back-to-back single-cycle ops: one accept per cycle, `opValid` high continuously.
- Accept-after-done: a new op may be accepted at T+N+1.
- `inReady` is combinational from state only (no input dependence).

## Configuration
- `ALUCU_DIV_EN` defined: DIV decode and `DIV_CYCLES` occupancy are compiled in.
- `ALUCU_DIV_EN` undefined:
  - Function code 1001 decodes as illegal (NOP, `illegal` pulse, no MULTI).
  - `DIV_CYCLES` is unused.
  - Counter is sized from `MUL_CYCLES` only.

## Structure
- Package `alu_ctrl_pkg` holds:
  - op encoding localparams (`OP_AND`…`OP_SLT`)
  - `aoi` codes (`AOI_ADD`, `AOI_SUB`, `AOI_RTYPE`, `AOI_OR`)
  - function-code constants
  - the FSM state enum.
- Sub-module `alu_ctrl_decode`: purely combinational decoder.
  - Inputs: `aoi`, `functionCode`.
  - Outputs: `op`, `isMulti`, `isDiv`, `illegal`.
  - Reused by the single-cycle core.
- Top `alu_ctrl_seq` holds the FSM, counter and output registers.

## Test plan
- Reset: `reset`=1 for 2 cycles → `op`=101, `opValid`=0, `busy`=0, `inReady`=1.
- Non-R-type `aoi`:
  - `aoi`=00 → `op`=010.
  - `aoi`=01 → `op`=110.
  - `aoi`=11 → `op`=001.
  - Each with a single `opValid` pulse one cycle after accept.
- R-type decode, `aoi`=10:
  - `functionCode`=0000 → 010.
  - 0101 → 001.
  - 0100 → 000.
  - 1010 → 111.
  - 1111 → 101 with `illegal`=1.
  - Back-to-back inputs give `opValid` high every cycle.
- Multiply (`MUL_CYCLES`=4):
  - `aoi`=10, fc=1000 accepted at T → `op`=011 at T+1.
  - `busy` T+1..T+4, `done` at T+4 only, `inReady`=1 at T+5.
  - An `inValid` held during busy is not accepted until T+5.
- Divide (`DIV_CYCLES`=8):
  - With `ALUCU_DIV_EN`: fc=1001 → `op`=100, `busy` 8 cycles.
  - Without `ALUCU_DIV_EN`: → `op`=101, `illegal`=1, `busy`=0.
- Reset at T+2 of a multiply → at T+3 `busy`=0, `done` never pulses, `op`=101, `inReady`=1.
